// File: rtl/ef_uart_pkg.sv
// Shared UART definitions: FSM states and oversampling constants.
package ef_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int         OVS  = 16;            // ticks per bit
    localparam logic [3:0] MID  = 4'd7;          // mid-bit tick of the start bit
    localparam logic [3:0] LAST = 4'(OVS - 1);   // last tick of a bit

endpackage

// File: rtl/ef_uart_rx_engine_if.sv
// RX engine to FIFO/status bus: push strobe, data and error pulses.
interface ef_uart_rx_engine_if #(
    parameter int DW = 8
);
    logic [DW-1:0] wdata;
    logic          wr;
    logic          frame_err;
    logic          brk;

    modport master (output wdata, wr, frame_err, brk);
    modport slave  (input  wdata, wr, frame_err, brk);
endinterface

// File: rtl/ef_uart_baud_gen.sv
// Prescale tick generator: one tick every prescale+1 clocks, synchronous clear.
module ef_uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);
    logic [15:0] pcnt;

    // '>=' rather than '==' so a live prescale shrink below pcnt ticks at once
    // instead of waiting for a 16-bit wrap.
    assign tick = !clr && (pcnt >= prescale);

    // Divider counter: restarts on clear or after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pcnt <= '0;
        else if (clr || tick) pcnt <= '0;
        else                  pcnt <= pcnt + 16'd1;
    end
endmodule

// File: rtl/ef_uart_rx_engine.sv
// UART receive engine: 16x oversampled 8N1 (DW data bits) frame recovery.
import ef_uart_pkg::*;

module ef_uart_rx_engine #(
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   rx_en,
    input  logic [15:0]            prescale,
    input  logic                   RX,
    ef_uart_rx_engine_if.master    bus
);
    localparam int            BW    = $clog2(DW);
    localparam logic [BW-1:0] BLAST = BW'(DW - 1);

    state_t          state, nxt;
    logic [SYNC-1:0] sync_q;
    logic            rx_s, rx_d, fall, run, tick, clr;
    logic [3:0]      scnt;
    logic [BW-1:0]   bcnt;
    logic [DW-1:0]   sr;
    logic [DW-1:0]   wdata_q;
    logic            wr_q, ferr_q, brk_q;

    assign run  = en & rx_en;
    assign rx_s = sync_q[SYNC-1];
    assign fall = rx_d & ~rx_s;
    // Tick counter held at zero while idle, so START always begins at pcnt=0.
    assign clr  = !run || (state == IDLE);

    // RX synchronizer and edge-detect delay; runs even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], RX};
            rx_d   <= rx_s;
        end
    end

    ef_uart_baud_gen u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .prescale (prescale),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        if (!run) nxt = IDLE;
        else begin
            unique case (state)
                IDLE:  if (fall) nxt = START;
                START: if (tick && scnt == MID) nxt = rx_s ? IDLE : DATA;
                DATA:  if (tick && scnt == LAST && bcnt == BLAST) nxt = STOP;
                STOP:  if (tick && scnt == LAST) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Counters, shift register and registered one-cycle output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt    <= '0;
            bcnt    <= '0;
            sr      <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
            brk_q  <= 1'b0;
            if (!run) begin
                scnt <= '0;
                bcnt <= '0;
                sr   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        scnt <= '0;
                        bcnt <= '0;
                    end
                    START: if (tick) scnt <= (scnt == MID) ? 4'd0 : scnt + 4'd1;
                    DATA: if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == LAST) begin
                            sr   <= {rx_s, sr[DW-1:1]};
                            bcnt <= (bcnt == BLAST) ? '0 : bcnt + 1'b1;
                        end
                    end
                    STOP: if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == LAST) begin
                            if (rx_s) begin
                                wr_q    <= 1'b1;
                                wdata_q <= sr;
                            end else begin
                                ferr_q <= 1'b1;
                                brk_q  <= (sr == '0);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wdata     = wdata_q;
    assign bus.wr        = wr_q;
    assign bus.frame_err = ferr_q;
    assign bus.brk       = brk_q;
endmodule
